sha1_round_sched: RTL

- Parametrised round scheduler for a pipelined SHA-1 core. It splits the 80 compression rounds across NUM_STAGES round engines.
- It generates per-stage busy, load and global-round-index signals, and carries a job tag through the stages.
- It reports completion with a registered done pulse and the finished job's tag.
- It sits between the host start interface and the stage datapaths and W-schedule engine. It is the successor of the fixed 4×20 busy-shifter chain, adding zero-bubble back-to-back issue, a global stall, tags and occupancy.

---
 rtl/sha1_round_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sha1_round_sched.sv
// -----------------------------------------------------------------------------
// sha1_round_sched
//   Round scheduler for a pipelined SHA-1 core. The 80 compression rounds are
//   split evenly across NUM_STAGES round engines, each running ROUNDS rounds.
//   A job enters stage 0 when the host start is acknowledged. It walks through
//   the stages and raises a registered done pulse with its tag after the last
//   round. Back-to-back jobs issue with no bubble. A global stall freezes every
//   stage.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start/start_tag   host issue request and the tag for that block
//   start_ack         combinational; the request is taken at this edge
//   stall             holds every stage counter for the cycle
//   stage_busy[k]     stage k holds a job
//   stage_load[k]     registered pulse in stage k's first active cycle
//   stage_round       7 bits per stage, global round index (0 when idle)
//   stage_tag         TAG_W bits per stage, tag held by stage k
//   busy              stage_busy[0]
//   occupancy         number of busy stages (registered)
//   done/done_tag     one-cycle completion pulse and the finished job's tag
// -----------------------------------------------------------------------------

// One round engine's control. It holds busy, a local round counter and the tag.
// A load takes priority over finishing, so a stage reloads in the same edge it
// hands its previous job on. This is what makes issue zero-bubble.
module sha1_round_stage #(
  parameter int ROUNDS = 20,
  parameter int TAG_W  = 4,
  parameter int BASE   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             load_i,
  input  logic [TAG_W-1:0] load_tag_i,
  output logic             busy_o,
  output logic             busy_nxt_o,
  output logic             last_o,
  output logic             load_o,
  output logic [6:0]       round_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int            LCW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [LCW-1:0] LC_LAST = LCW'(ROUNDS - 1);
  localparam logic [6:0]     RBASE   = 7'(BASE);

  logic             busy_q, busy_d;
  logic [LCW-1:0]   lc_q, lc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             load_q, load_d;
  logic             last;

  assign last = busy_q & (lc_q == LC_LAST);

  always_comb begin
    busy_d = busy_q;
    lc_d   = lc_q;
    tag_d  = tag_q;
    load_d = 1'b0;
    if (!stall_i) begin
      if (load_i) begin
        busy_d = 1'b1;
        lc_d   = '0;
        tag_d  = load_tag_i;
        load_d = 1'b1;
      end else if (last) begin
        busy_d = 1'b0;
        lc_d   = '0;
      end else if (busy_q) begin
        lc_d   = lc_q + LCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      lc_q   <= '0;
      tag_q  <= '0;
      load_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      lc_q   <= lc_d;
      tag_q  <= tag_d;
      load_q <= load_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_nxt_o = busy_d;
  assign last_o     = last;
  assign load_o     = load_q;
  assign tag_o      = tag_q;
  // Idle stages report round 0 so that downstream W-schedule indexing stays clean.
  assign round_o    = busy_q ? (RBASE + 7'(lc_q)) : 7'd0;
endmodule

module sha1_round_sched #(
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [TAG_W-1:0]                  start_tag,
  output logic                              start_ack,
  input  logic                              stall,
  output logic [NUM_STAGES-1:0]             stage_busy,
  output logic [NUM_STAGES-1:0]             stage_load,
  output logic [7*NUM_STAGES-1:0]           stage_round,
  output logic [TAG_W*NUM_STAGES-1:0]       stage_tag,
  output logic                              busy,
  output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy,
  output logic                              done,
  output logic [TAG_W-1:0]                  done_tag
);
  localparam int ROUNDS = 80 / NUM_STAGES;
  localparam int OCC_W  = $clog2(NUM_STAGES + 1);

  if ((80 % NUM_STAGES) != 0) begin : g_bad_num_stages
    $error("sha1_round_sched: NUM_STAGES must divide 80");
  end

  logic [NUM_STAGES-1:0]             busy_s, busy_nxt_s, last_s, load_s, ld_in;
  logic [NUM_STAGES-1:0][TAG_W-1:0]  tag_s, ld_tag_in;
  logic [NUM_STAGES-1:0][6:0]        round_s;

  // Stage 0 can take a new block when it is empty or finishing this edge.
  assign start_ack = start & ~stall & (~busy_s[0] | last_s[0]);

  // Load chain: stage 0 loads from issue, stage k from stage k-1's last round.
  assign ld_in[0]     = start_ack;
  assign ld_tag_in[0] = start_tag;
  if (NUM_STAGES > 1) begin : g_chain
    assign ld_in[NUM_STAGES-1:1]     = last_s[NUM_STAGES-2:0];
    assign ld_tag_in[NUM_STAGES-1:1] = tag_s[NUM_STAGES-2:0];
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    sha1_round_stage #(
      .ROUNDS (ROUNDS),
      .TAG_W  (TAG_W),
      .BASE   (k * ROUNDS)
    ) u_stage (
      .clk        (clk),
      .rst        (reset),
      .stall_i    (stall),
      .load_i     (ld_in[k]),
      .load_tag_i (ld_tag_in[k]),
      .busy_o     (busy_s[k]),
      .busy_nxt_o (busy_nxt_s[k]),
      .last_o     (last_s[k]),
      .load_o     (load_s[k]),
      .round_o    (round_s[k]),
      .tag_o      (tag_s[k])
    );
  end

  // Completion and occupancy bookkeeping.
  logic             done_q, done_d;
  logic [TAG_W-1:0] done_tag_q, done_tag_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    done_d     = ~stall & last_s[NUM_STAGES-1];
    done_tag_d = done_d ? tag_s[NUM_STAGES-1] : done_tag_q;
    // Registering the popcount of next-state busy keeps occupancy aligned with stage_busy.
    occ_d      = OCC_W'($countones(busy_nxt_s));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      done_tag_q <= '0;
      occ_q      <= '0;
    end else begin
      done_q     <= done_d;
      done_tag_q <= done_tag_d;
      occ_q      <= occ_d;
    end
  end

  assign stage_busy  = busy_s;
  assign stage_load  = load_s;
  assign stage_round = round_s;
  assign stage_tag   = tag_s;
  assign busy        = busy_s[0];
  assign occupancy   = occ_q;
  assign done        = done_q;
  assign done_tag    = done_tag_q;
endmodule
